// File: rtl/sga_direction_encoder_if.sv
// -----------------------------------------------------------------------------
// sga_direction_encoder_if
// Bundles the button inputs, control-unit strobes and direction outputs of the
// snake-game direction encoder.
//
// Signals:
//   buttons[3:0]  raw push-buttons, active-high ([0]=X+, [1]=X-, [2]=Y+, [3]=Y-)
//   enable        high while a game is running
//   load_default  one-cycle pulse: committed direction -> 00, pending cleared
//   move_tick     one-cycle pulse at each head-position commit
//   direction     committed direction code (00 X+, 01 X-, 10 Y+, 11 Y-)
//   pending       an accepted request is waiting for move_tick
//   played        one-cycle pulse on any debounced button rising edge
//   accepted      one-cycle pulse when a request is written into pending
//   state_dbg     control FSM state (0 = IDLE, 1 = ARMED)
//
// Handshake: there is no valid/ready pairing on this bus. load_default and
// move_tick are single-cycle strobes sampled on every rising clock edge;
// played and accepted are single-cycle strobes that the consumer must sample
// on the cycle they are high (they are never held or retried).
//
// Modports:
//   slave  - the encoder itself
//   master - the control unit / testbench side
// -----------------------------------------------------------------------------
interface sga_direction_encoder_if;
    logic [3:0] buttons;
    logic       enable;
    logic       load_default;
    logic       move_tick;
    logic [1:0] direction;
    logic       pending;
    logic       played;
    logic       accepted;
    logic       state_dbg;

    modport slave (
        input  buttons,
        input  enable,
        input  load_default,
        input  move_tick,
        output direction,
        output pending,
        output played,
        output accepted,
        output state_dbg
    );

    modport master (
        output buttons,
        output enable,
        output load_default,
        output move_tick,
        input  direction,
        input  pending,
        input  played,
        input  accepted,
        input  state_dbg
    );
endinterface

// File: rtl/sga_direction_encoder.sv
// -----------------------------------------------------------------------------
// sga_direction_encoder
// Turns four raw push-buttons into a committed snake direction. Each button is
// synchronised (2 FFs), debounced (DEBOUNCE_CYCLES stable samples) and
// edge-detected. A debounced rising edge becomes a direction request which,
// if it is neither a repeat of the reference direction nor a reversal of the
// committed direction, is parked in a single-entry pending register until the
// next move_tick commits it.
//
// Parameters:
//   DEBOUNCE_CYCLES  stable synchronised samples needed to accept a change
//   CNT_W            debounce counter width, 2**CNT_W > DEBOUNCE_CYCLES
//
// Ports:
//   clock  system clock, rising edge
//   reset  asynchronous, active-high, clears all state
//   bus    sga_direction_encoder_if.slave (buttons, strobes, outputs)
// -----------------------------------------------------------------------------
module sga_direction_encoder #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    sga_direction_encoder_if.slave  bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Button front end
    logic [3:0]       sync1_q;
    logic [3:0]       sync2_q;
    logic [3:0]       deb_q;
    logic [3:0]       deb_d_q;
    logic [CNT_W-1:0] cnt_q [4];
    logic [3:0]       rise;

    // Request decode
    logic       req_valid;
    logic [1:0] req_code;

    // Control
    state_t     state_q;
    state_t     state_d;
    logic [1:0] dir_q;
    logic [1:0] pend_code_q;
    logic       pending;
    logic       commit_fire;
    logic [1:0] commit_dir;
    logic [1:0] ref_dir;
    logic       reversal;
    logic       accept;
    logic       played_q;
    logic       accepted_q;

    // -------------------------------------------------------------------------
    // Synchroniser, debouncer and edge-detect history
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            deb_d_q <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= bus.buttons;
            sync2_q <= sync1_q;
            deb_d_q <= deb_q;
            for (int i = 0; i < 4; i++) begin
                if (sync2_q[i] == deb_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CNT_MAX) begin
                    // DEBOUNCE_CYCLES consecutive disagreeing samples seen
                    cnt_q[i] <= '0;
                    deb_q[i] <= ~deb_q[i];
                end else begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign rise = deb_q & ~deb_d_q;

    // Lowest button index wins when several edges land in the same cycle;
    // the button index is also the direction code.
    always_comb begin
        req_valid = |rise;
        req_code  = 2'b11;
        if (rise[0]) begin
            req_code = 2'b00;
        end else if (rise[1]) begin
            req_code = 2'b01;
        end else if (rise[2]) begin
            req_code = 2'b10;
        end
    end

    // -------------------------------------------------------------------------
    // Request evaluation
    // -------------------------------------------------------------------------
    assign pending     = (state_q == ARMED);
    assign commit_fire = bus.move_tick && pending;

    // On a move_tick cycle the old pending code is committed first, so both
    // the duplicate check and the reversal check see the post-commit value.
    assign commit_dir  = commit_fire ? pend_code_q : dir_q;
    assign ref_dir     = bus.move_tick ? commit_dir
                                       : (pending ? pend_code_q : dir_q);
    // Same axis (bit 1 equal), opposite sense (bit 0 differs)
    assign reversal    = (req_code[1] == commit_dir[1]) &&
                         (req_code[0] != commit_dir[0]);
    assign accept      = bus.enable && !bus.load_default && req_valid &&
                         (req_code != ref_dir) && !reversal;

    // -------------------------------------------------------------------------
    // Control FSM: IDLE = nothing pending, ARMED = request awaiting move_tick
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.load_default || !bus.enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_d = ARMED;
                    end
                end
                ARMED: begin
                    // A simultaneous accept re-arms with the new code
                    if (accept) begin
                        state_d = ARMED;
                    end else if (bus.move_tick) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Direction / pending code registers and output strobes
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dir_q       <= 2'b00;
            pend_code_q <= 2'b00;
            played_q    <= 1'b0;
            accepted_q  <= 1'b0;
        end else begin
            played_q   <= req_valid;
            accepted_q <= accept;
            if (bus.load_default) begin
                dir_q       <= 2'b00;
                pend_code_q <= 2'b00;
            end else begin
                if (bus.enable && commit_fire) begin
                    dir_q <= pend_code_q;
                end
                if (accept) begin
                    pend_code_q <= req_code;
                end
            end
        end
    end

    assign bus.direction = dir_q;
    assign bus.pending   = pending;
    assign bus.played    = played_q;
    assign bus.accepted  = accepted_q;
    assign bus.state_dbg = logic'(state_q);

endmodule

// File: tb/tb_sga_direction_encoder.sv
// -----------------------------------------------------------------------------
// tb_sga_direction_encoder
// Directed bench for sga_direction_encoder with DEBOUNCE_CYCLES=4, so a clean
// press produces played/accepted exactly 7 rising edges after the raw input
// goes high. Inputs change 1 time unit after a rising edge; outputs are
// observed at the same point, i.e. after the edge has settled.
// -----------------------------------------------------------------------------
module tb_sga_direction_encoder;

    localparam int DEB = 4;
    localparam int CW  = 3;

    logic clock;
    logic reset;

    sga_direction_encoder_if bus ();

    sga_direction_encoder #(
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (CW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int n_checks   = 0;
    int n_pass     = 0;
    int n_fail     = 0;
    int played_cnt = 0;
    int base_cnt   = 0;

    // -------------------------------------------------------------------------
    // Clock / reset
    // -------------------------------------------------------------------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Total number of played pulses, sampled mid-cycle
    always @(negedge clock) begin
        if (bus.played === 1'b1) begin
            played_cnt++;
        end
    end

    // -------------------------------------------------------------------------
    // Driver tasks
    // -------------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic exp_played,
                             input logic exp_accepted, input logic exp_pending);
        check({tag, "_played"},   32'(bus.played),   32'(exp_played));
        check({tag, "_accepted"}, 32'(bus.accepted), 32'(exp_accepted));
        check({tag, "_pending"},  32'(bus.pending),  32'(exp_pending));
    endtask

    // Drive mask, confirm nothing fires one edge early, then step onto the
    // edge where played is due.
    task automatic press(input logic [3:0] mask, input string tag);
        bus.buttons = mask;
        tick(6);
        check({tag, "_early"}, 32'(bus.played), 32'd0);
        tick(1);
    endtask

    task automatic release_all();
        bus.buttons = 4'b0000;
        tick(8);
    endtask

    task automatic commit();
        bus.move_tick = 1'b1;
        tick(1);
        bus.move_tick = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    // Directed sequence
    // -------------------------------------------------------------------------
    initial begin
        reset            = 1'b1;
        bus.buttons      = 4'b0001;   // held through reset
        bus.enable       = 1'b1;
        bus.load_default = 1'b0;
        bus.move_tick    = 1'b0;
        tick(2);
        check("rst_dir",      32'(bus.direction), 32'd0);
        check("rst_state",    32'(bus.state_dbg), 32'd0);
        check_out("rst", 1'b0, 1'b0, 1'b0);

        // Button held through reset: full latency after release; X+ equals
        // the committed 00 so it is not accepted.
        reset = 1'b0;
        tick(6);
        check("held_early", 32'(bus.played), 32'd0);
        tick(1);
        check_out("held", 1'b1, 1'b0, 1'b0);
        release_all();
        check("held_fall_cnt", 32'(played_cnt), 32'd1);

        // Clean Y+ press
        press(4'b0100, "ypress");
        check_out("ypress", 1'b1, 1'b1, 1'b1);
        check("ypress_state", 32'(bus.state_dbg), 32'd1);
        tick(1);
        check_out("ypress_after", 1'b0, 1'b0, 1'b1);
        release_all();
        commit();
        check("ycommit_dir", 32'(bus.direction), 32'h2);
        check("ycommit_pending", 32'(bus.pending), 32'd0);

        // Reversal rejection from 00
        bus.load_default = 1'b1;
        tick(1);
        bus.load_default = 1'b0;
        check("ld_dir", 32'(bus.direction), 32'd0);
        press(4'b0010, "rev1");
        check_out("rev1", 1'b1, 1'b0, 1'b0);
        release_all();
        press(4'b0100, "rev_y");
        check_out("rev_y", 1'b1, 1'b1, 1'b1);
        release_all();
        press(4'b0010, "rev2");
        check_out("rev2", 1'b1, 1'b0, 1'b1);
        release_all();
        commit();
        check("rev_commit_dir", 32'(bus.direction), 32'h2);

        // Glitches of 1..3 cycles on X+ are swallowed
        base_cnt = played_cnt;
        for (int len = 1; len <= 3; len++) begin
            bus.buttons = 4'b0001;
            tick(len);
            bus.buttons = 4'b0000;
            tick(8);
        end
        check("glitch_cnt", 32'(played_cnt), 32'(base_cnt));
        // Latency still exact afterwards, so counters went back to 0
        press(4'b0001, "post_glitch");
        check_out("post_glitch", 1'b1, 1'b1, 1'b1);
        release_all();
        // Overwrite pending 00 with 01 (direction is 10)
        press(4'b0010, "overwrite");
        check_out("overwrite", 1'b1, 1'b1, 1'b1);
        release_all();
        commit();
        check("overwrite_dir", 32'(bus.direction), 32'h1);

        // Simultaneous X+ and Y- from direction 10
        press(4'b0100, "to_y");
        release_all();
        commit();
        check("to_y_dir", 32'(bus.direction), 32'h2);
        press(4'b1001, "simul");
        check_out("simul", 1'b1, 1'b1, 1'b1);
        release_all();
        commit();
        check("simul_dir", 32'(bus.direction), 32'h0);

        // move_tick and accepted edge in the same cycle
        press(4'b1000, "yminus");
        check_out("yminus", 1'b1, 1'b1, 1'b1);
        release_all();
        bus.buttons = 4'b0001;
        tick(6);
        check("same_early", 32'(bus.played), 32'd0);
        bus.move_tick = 1'b1;
        tick(1);
        bus.move_tick = 1'b0;
        check("same_dir", 32'(bus.direction), 32'h3);
        check_out("same", 1'b1, 1'b1, 1'b1);
        release_all();
        commit();
        check("same_commit_dir", 32'(bus.direction), 32'h0);

        // enable=0: requests ignored, pending dropped, direction held
        bus.enable = 1'b0;
        press(4'b0100, "dis");
        check_out("dis", 1'b1, 1'b0, 1'b0);
        release_all();
        bus.enable = 1'b1;
        press(4'b1000, "en");
        check_out("en", 1'b1, 1'b1, 1'b1);
        release_all();
        bus.enable = 1'b0;
        tick(1);
        check("dis_pending", 32'(bus.pending), 32'd0);
        check("dis_state", 32'(bus.state_dbg), 32'd0);
        commit();
        check("dis_dir", 32'(bus.direction), 32'h0);
        bus.enable = 1'b1;
        tick(1);
        check("reen_pending", 32'(bus.pending), 32'd0);

        // load_default beats move_tick
        press(4'b0100, "ld_y");
        release_all();
        commit();
        check("ld_y_dir", 32'(bus.direction), 32'h2);
        press(4'b0010, "ld_x");
        check_out("ld_x", 1'b1, 1'b1, 1'b1);
        release_all();
        bus.load_default = 1'b1;
        bus.move_tick    = 1'b1;
        tick(1);
        bus.load_default = 1'b0;
        bus.move_tick    = 1'b0;
        check("ld_prio_dir", 32'(bus.direction), 32'h0);
        check("ld_prio_pending", 32'(bus.pending), 32'd0);

        // Asynchronous reset while ARMED and mid-debounce
        press(4'b0100, "ar_y");
        release_all();
        commit();
        check("ar_y_dir", 32'(bus.direction), 32'h2);
        press(4'b0001, "ar_x");
        check_out("ar_x", 1'b1, 1'b1, 1'b1);
        release_all();
        base_cnt = played_cnt;
        bus.buttons = 4'b1000;
        tick(4);
        #2 reset = 1'b1;
        #1;
        check("ar_dir", 32'(bus.direction), 32'h0);
        check("ar_pending", 32'(bus.pending), 32'd0);
        check("ar_state", 32'(bus.state_dbg), 32'd0);
        bus.buttons = 4'b0000;
        tick(2);
        reset = 1'b0;
        tick(12);
        check("ar_no_pulse", 32'(played_cnt), 32'(base_cnt));
        check_out("ar_after", 1'b0, 1'b0, 1'b0);
        check("ar_after_dir", 32'(bus.direction), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
